// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
package dpram_pkg;

    // Sequencer states: zero-clearing the array, then serving port requests.
    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    // Read-during-write selection for same-address accesses.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Number of byte lanes in one data word.
    function automatic int lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/dpram_lane_merge.sv
// Combinational byte-lane merge: enabled lanes come from new_word, the rest from old_word.
module dpram_lane_merge
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]                        old_word,
    input  logic [DATA_WIDTH-1:0]                        new_word,
    input  logic [lanes(DATA_WIDTH, BYTE_WIDTH)-1:0]     be,
    output logic [DATA_WIDTH-1:0]                        merged
);

    localparam int NUM_LANES = lanes(DATA_WIDTH, BYTE_WIDTH);

    // Start from the old word and overlay every enabled lane.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/dual_port_ram_be.sv
// Dual-port RAM with byte-enabled write port, gated synchronous read port,
// selectable read-during-write behaviour, optional output register, and a
// post-reset sequencer that zero-clears the whole array.
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]              addr_wr,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              addr_rd,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               dout_valid,
    output logic                               busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("dual_port_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic                  ready;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] old_wr_word;
    logic [DATA_WIDTH-1:0] old_rd_word;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    assign ready       = (state_q == ST_READY);
    assign busy        = ~ready;
    assign wr_ok       = ready & we;
    assign rd_ok       = ready & re;
    assign old_wr_word = mem_q[addr_wr];
    assign old_rd_word = mem_q[addr_rd];

    // One merge serves both the write data and same-address forwarding,
    // since on an address match both see the same old word.
    dpram_lane_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_merge (
        .old_word (old_wr_word),
        .new_word (din),
        .be       (be),
        .merged   (wr_merged)
    );

    // Next-state logic: walk the clear counter until the last entry is written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    // Sequencer state register; reset restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single memory write port shared by the clear sequencer and the user port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_wr;
        mem_wdata = wr_merged;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_WIDTH-1:0];
                mem_wdata = '0;
            end else if (wr_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array; contents are defined by the clear sequence, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read word selection, forwarding the merged write on a same-address hit in write-first mode.
    always_comb begin
        rd_word = old_rd_word;
        if ((RDW_MODE == RDW_NEW) && wr_ok && (addr_wr == addr_rd)) begin
            rd_word = wr_merged;
        end
        s1_valid_d = rd_ok;
        s1_data_d  = rd_ok ? rd_word : s1_data_q;
    end

    // First read stage; data holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_q, s2_valid_d;
        logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

        // Output stage captures only completed first-stage reads.
        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        // Output register, flushed on reset so in-flight reads are dropped.
        always_ff @(posedge clk) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign dout       = s2_data_q;
        assign dout_valid = s2_valid_q;
    end else begin : g_no_out_reg
        assign dout       = s1_data_q;
        assign dout_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench driving two RAM variants with shared stimulus:
// instance A is write-first with output register, B is read-first without.
module tb_dual_port_ram_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int NL    = DW / BW;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [NL-1:0] be = '0;
    logic [AW-1:0] addr_wr = '0;
    logic [AW-1:0] addr_rd = '0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          dout_valid_a, dout_valid_b;
    logic          busy_a, busy_b;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_ready = 1'b0;
    int            cyc = 0;
    int            num_checks = 0;
    int            num_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_be #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BYTE_WIDTH (BW), .OUT_REG (1), .RDW_MODE (1)
    ) dut_a (
        .clk (clk), .reset (reset), .we (we), .be (be), .addr_wr (addr_wr), .din (din),
        .re (re), .addr_rd (addr_rd), .dout (dout_a), .dout_valid (dout_valid_a), .busy (busy_a)
    );

    dual_port_ram_be #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BYTE_WIDTH (BW), .OUT_REG (0), .RDW_MODE (0)
    ) dut_b (
        .clk (clk), .reset (reset), .we (we), .be (be), .addr_wr (addr_wr), .din (din),
        .re (re), .addr_rd (addr_rd), .dout (dout_b), .dout_valid (dout_valid_b), .busy (busy_b)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] mergeModel(input logic [DW-1:0] old_word,
                                                 input logic [DW-1:0] new_word,
                                                 input logic [NL-1:0] lanes_en);
        logic [DW-1:0] r;
        r = old_word;
        for (int i = 0; i < NL; i++) begin
            if (lanes_en[i]) r[i*BW +: BW] = new_word[i*BW +: BW];
        end
        return r;
    endfunction

    // Drive one cycle of port activity and record the expected read results.
    task automatic applyStimulus(input logic w, input logic [NL-1:0] b, input logic [AW-1:0] aw,
                                 input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ar);
        logic [DW-1:0] merged;
        logic [DW-1:0] old_word;
        exp_t          e;
        we = w; be = b; addr_wr = aw; din = d; re = r; addr_rd = ar;
        if (model_ready) begin
            merged = mergeModel(model_mem[aw], d, b);
            if (r) begin
                old_word = model_mem[ar];
                e.data = (w && aw == ar) ? merged : old_word;
                e.due  = cyc + 2;
                q_a.push_back(e);
                e.data = old_word;
                e.due  = cyc + 1;
                q_b.push_back(e);
            end
            if (w) model_mem[aw] = merged;
        end
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Assert reset for one edge, drop reads that would complete after it,
    // then time the clear sequence, optionally poking the ports while busy.
    task automatic doReset(input bit pulse);
        exp_t tmp[$];
        int   n;
        model_ready = 1'b0;
        reset = 1'b1;
        tmp.delete();
        for (int i = 0; i < q_a.size(); i++) if (q_a[i].due <= cyc) tmp.push_back(q_a[i]);
        q_a = tmp;
        tmp.delete();
        for (int i = 0; i < q_b.size(); i++) if (q_b[i].due <= cyc) tmp.push_back(q_b[i]);
        q_b = tmp;
        @(posedge clk); #1;
        checkOutput("rst_dout_a", dout_a, '0);
        checkOutput("rst_valid_a", {31'd0, dout_valid_a}, '0);
        checkOutput("rst_busy_a", {31'd0, busy_a}, 32'd1);
        checkOutput("rst_dout_b", dout_b, '0);
        checkOutput("rst_valid_b", {31'd0, dout_valid_b}, '0);
        checkOutput("rst_busy_b", {31'd0, busy_b}, 32'd1);
        reset = 1'b0;
        we = 1'b0;
        re = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            if (pulse && n < 3) begin
                we = 1'b1; be = '1; addr_wr = '0; din = 32'hFFFF_FFFF; re = 1'b1; addr_rd = '0;
            end else begin
                we = 1'b0; re = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        we = 1'b0;
        re = 1'b0;
        checkOutput("busy_cycles", 32'(n), 32'(DEPTH));
        checkOutput("busy_a_low", {31'd0, busy_a}, '0);
        checkOutput("busy_b_low", {31'd0, busy_b}, '0);
        model_ready = 1'b1;
    endtask

    exp_t ea;
    exp_t eb;

    // Scoreboard for instance A: every valid pulse must match the oldest pending read.
    always @(negedge clk) begin
        if (q_a.size() > 0 && q_a[0].due < cyc) begin
            ea = q_a.pop_front();
            checkOutput("a_missing_valid", {31'd0, dout_valid_a}, 32'd1);
        end
        if (dout_valid_a) begin
            if (q_a.size() == 0) begin
                checkOutput("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                checkOutput("a_data", dout_a, ea.data);
                checkOutput("a_latency", 32'(cyc), 32'(ea.due));
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (q_b.size() > 0 && q_b[0].due < cyc) begin
            eb = q_b.pop_front();
            checkOutput("b_missing_valid", {31'd0, dout_valid_b}, 32'd1);
        end
        if (dout_valid_b) begin
            if (q_b.size() == 0) begin
                checkOutput("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                checkOutput("b_data", dout_b, eb.data);
                checkOutput("b_latency", 32'(cyc), 32'(eb.due));
            end
        end
    end

    initial begin
        doReset(1'b0);

        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
        idleCycles(3);

        applyStimulus(1'b1, 4'b1111, 4'd3, 32'hDEAD_BEEF, 1'b0, '0);
        applyStimulus(1'b1, 4'b0101, 4'd3, 32'h1122_3344, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3);
        idleCycles(4);
        checkOutput("hold_a", dout_a, 32'hDE22_BE44);
        checkOutput("hold_valid_a", {31'd0, dout_valid_a}, '0);
        checkOutput("hold_b", dout_b, 32'hDE22_BE44);
        checkOutput("hold_valid_b", {31'd0, dout_valid_b}, '0);

        applyStimulus(1'b1, 4'b1111, 4'd5, 32'h0102_0304, 1'b0, '0);
        applyStimulus(1'b1, 4'b1100, 4'd5, 32'hAABB_CCDD, 1'b1, 4'd5);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5);
        applyStimulus(1'b1, 4'b1111, 4'd6, 32'hCAFE_F00D, 1'b1, 4'd3);
        applyStimulus(1'b1, 4'b0000, 4'd6, 32'h5555_5555, 1'b1, 4'd6);
        idleCycles(3);

        for (int a = 0; a < 8; a++) applyStimulus(1'b1, 4'b1111, AW'(a), 32'(a * 16), 1'b0, '0);
        for (int a = 0; a < 8; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
        idleCycles(3);

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7);
        re = 1'b1;
        addr_rd = 4'd6;
        doReset(1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7);
        idleCycles(5);

        checkOutput("a_drained", 32'(q_a.size()), 32'd0);
        checkOutput("b_drained", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
